// File: rtl/wb_queue_pkg.sv
// Shared CPU constants and the writeback queue entry type.
package wb_queue_pkg;

    localparam int unsigned REG_ID_W = 4;
    localparam int unsigned NUM_REGS = 16;
    localparam int unsigned DATA_W   = 16;

    typedef logic [REG_ID_W-1:0] reg_id_t;

    typedef struct packed {
        reg_id_t           id;
        logic [DATA_W-1:0] data;
    } entry_t;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_id_t id);
        return NUM_REGS'(1) << id;
    endfunction

endpackage

// File: rtl/wb_queue_if.sv
// Writeback queue bus: two producer ports, hold, register-file write port and status.
interface wb_queue_if
    import wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                mem_valid;
    reg_id_t             mem_reg;
    logic [DATA_W-1:0]   mem_data;
    logic                mem_ready;
    logic                alu_valid;
    reg_id_t             alu_reg;
    logic [DATA_W-1:0]   alu_data;
    logic                alu_ready;
    logic                hold;
    logic                WriteReg;
    reg_id_t             DstReg;
    logic [DATA_W-1:0]   DstData;
    logic [NUM_REGS-1:0] pending;
    logic [CNT_W-1:0]    count;

    modport slave (
        input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, hold,
        output mem_ready, alu_ready, WriteReg, DstReg, DstData, pending, count
    );

    modport master (
        output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data, hold,
        input  mem_ready, alu_ready, WriteReg, DstReg, DstData, pending, count
    );

endinterface

// File: rtl/wb_fifo.sv
// Circular storage for queued writebacks; pointers wrap naturally since DEPTH is a power of two.
module wb_fifo
    import wb_queue_pkg::*;
#(
    parameter  int unsigned DEPTH  = 4,
    parameter  int unsigned DATA_W = 16,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  reg_id_t                push_reg_i,
    input  logic [DATA_W-1:0]      push_data_i,
    input  logic                   pop_i,
    output reg_id_t                head_reg_o,
    output logic [DATA_W-1:0]      head_data_o,
    output logic [CNT_W-1:0]       count_o,
    output logic [PTR_W-1:0]       rd_ptr_o,
    output reg_id_t [DEPTH-1:0]    regs_o
);

    reg_id_t [DEPTH-1:0] reg_q;
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is defined solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (!rst && push_i) begin
            reg_q[wr_ptr_q]  <= push_reg_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_reg_o  = reg_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign count_o     = count_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign regs_o      = reg_q;

endmodule

// File: rtl/wb_queue.sv
// Register-file writeback queue: fixed-priority arbitration of memory over ALU results,
// in-order draining through a registered write stage, and per-register pending tracking.
module wb_queue
    import wb_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 16
) (
    input logic        clk,
    input logic        rst,
    wb_queue_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                full_c;
    logic                mem_ready_c;
    logic                alu_ready_c;
    logic                push_c;
    reg_id_t             push_reg_c;
    logic [DATA_W-1:0]   push_data_c;
    logic                pop_c;
    reg_id_t             head_reg;
    logic [DATA_W-1:0]   head_data;
    logic [CNT_W-1:0]    count;
    logic [PTR_W-1:0]    rd_ptr;
    reg_id_t [DEPTH-1:0] regs;
    logic [NUM_REGS-1:0] pending_c;

    logic                write_q;
    reg_id_t             dst_reg_q;
    logic [DATA_W-1:0]   dst_data_q;

    assign full_c      = (count == CNT_W'(DEPTH));
    assign mem_ready_c = !full_c;
    assign alu_ready_c = !full_c && !bus.mem_valid;
    assign pop_c       = (count != '0) && !bus.hold;

    // Memory port wins; the ALU source holds its request until granted.
    always_comb begin
        push_c      = 1'b0;
        push_reg_c  = bus.mem_reg;
        push_data_c = bus.mem_data;
        if (bus.mem_valid && mem_ready_c) begin
            push_c = 1'b1;
        end else if (bus.alu_valid && alu_ready_c) begin
            push_c      = 1'b1;
            push_reg_c  = bus.alu_reg;
            push_data_c = bus.alu_data;
        end
    end

    wb_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_c),
        .push_reg_i  (push_reg_c),
        .push_data_i (push_data_c),
        .pop_i       (pop_c),
        .head_reg_o  (head_reg),
        .head_data_o (head_data),
        .count_o     (count),
        .rd_ptr_o    (rd_ptr),
        .regs_o      (regs)
    );

    // Output stage: one-cycle write strobe, destination held between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q    <= 1'b0;
            dst_reg_q  <= '0;
            dst_data_q <= '0;
        end else begin
            write_q <= pop_c;
            if (pop_c) begin
                dst_reg_q  <= head_reg;
                dst_data_q <= head_data;
            end
        end
    end

    // Only entries still in the FIFO count; the output stage is bypassed by the register file.
    always_comb begin
        pending_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count) begin
                pending_c = pending_c | reg_onehot(regs[rd_ptr + PTR_W'(i)]);
            end
        end
    end

    assign bus.mem_ready = mem_ready_c;
    assign bus.alu_ready = alu_ready_c;
    assign bus.WriteReg  = write_q;
    assign bus.DstReg    = dst_reg_q;
    assign bus.DstData   = dst_data_q;
    assign bus.pending   = pending_c;
    assign bus.count     = count;

endmodule

// File: tb/tb_wb_queue.sv
// Directed scenario bench for the writeback queue with hand-computed expectations.
module tb_wb_queue;
    import wb_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wb_queue_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus();

    wb_queue #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mem_valid = 1'b0;
        bus.mem_reg   = '0;
        bus.mem_data  = '0;
        bus.alu_valid = 1'b0;
        bus.alu_reg   = '0;
        bus.alu_data  = '0;
        bus.hold      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.WriteReg !== 1'b0) begin errors++; $display("FAIL reset_write got %b want 0", bus.WriteReg); end
        checks++; if (bus.pending !== 16'h0000) begin errors++; $display("FAIL reset_pending got %h want 0000", bus.pending); end
        checks++; if (bus.DstReg !== 4'd0) begin errors++; $display("FAIL reset_dstreg got %0d want 0", bus.DstReg); end
        checks++; if (bus.DstData !== 16'h0000) begin errors++; $display("FAIL reset_dstdata got %h want 0000", bus.DstData); end
        checks++; if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got mem=%b alu=%b want 1 1", bus.mem_ready, bus.alu_ready);
        end
    endtask

    task automatic test_single_alu();
        bus.alu_valid = 1'b1;
        bus.alu_reg   = 4'd3;
        bus.alu_data  = 16'h1234;
        #1;
        checks++; if (bus.alu_ready !== 1'b1) begin errors++; $display("FAIL single_alu_ready got %b want 1", bus.alu_ready); end
        step();
        bus.alu_valid = 1'b0;
        checks++; if (bus.count !== 3'd1) begin errors++; $display("FAIL single_count got %0d want 1", bus.count); end
        checks++; if (bus.pending !== 16'h0008) begin errors++; $display("FAIL single_pending got %h want 0008", bus.pending); end
        checks++; if (bus.WriteReg !== 1'b0) begin errors++; $display("FAIL single_early_write got %b want 0", bus.WriteReg); end
        step();
        checks++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd3 || bus.DstData !== 16'h1234) begin
            errors++; $display("FAIL single_write got we=%b r%0d %h want 1 r3 1234", bus.WriteReg, bus.DstReg, bus.DstData);
        end
        checks++; if (bus.pending !== 16'h0000 || bus.count !== 3'd0) begin
            errors++; $display("FAIL single_drained got pend=%h cnt=%0d want 0000 0", bus.pending, bus.count);
        end
        step();
        checks++; if (bus.WriteReg !== 1'b0 || bus.DstReg !== 4'd3 || bus.DstData !== 16'h1234) begin
            errors++; $display("FAIL single_retain got we=%b r%0d %h want 0 r3 1234", bus.WriteReg, bus.DstReg, bus.DstData);
        end
    endtask

    task automatic test_priority();
        bus.mem_valid = 1'b1; bus.mem_reg = 4'd1; bus.mem_data = 16'hAAAA;
        bus.alu_valid = 1'b1; bus.alu_reg = 4'd2; bus.alu_data = 16'h5555;
        #1;
        checks++; if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b1) begin
            errors++; $display("FAIL prio_ready got mem=%b alu=%b want 1 0", bus.mem_ready, bus.alu_ready);
        end
        step();
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.alu_ready !== 1'b1 || bus.count !== 3'd1) begin
            errors++; $display("FAIL prio_alu_grant got alu=%b cnt=%0d want 1 1", bus.alu_ready, bus.count);
        end
        step();
        bus.alu_valid = 1'b0;
        checks++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd1 || bus.DstData !== 16'hAAAA) begin
            errors++; $display("FAIL prio_first got we=%b r%0d %h want 1 r1 aaaa", bus.WriteReg, bus.DstReg, bus.DstData);
        end
        step();
        checks++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'd2 || bus.DstData !== 16'h5555) begin
            errors++; $display("FAIL prio_second got we=%b r%0d %h want 1 r2 5555", bus.WriteReg, bus.DstReg, bus.DstData);
        end
        step();
        checks++; if (bus.WriteReg !== 1'b0) begin errors++; $display("FAIL prio_idle got %b want 0", bus.WriteReg); end
    endtask

    task automatic test_hold();
        bus.hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_valid = 1'b1;
            bus.mem_reg   = 4'(4 + i);
            bus.mem_data  = 16'(16'h0040 + i);
            step();
        end
        bus.mem_valid = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd4 || bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
            errors++; $display("FAIL hold_full got cnt=%0d mem=%b alu=%b want 4 0 0", bus.count, bus.mem_ready, bus.alu_ready);
        end
        checks++; if (bus.pending !== 16'h00F0) begin errors++; $display("FAIL hold_pending got %h want 00f0", bus.pending); end
        checks++; if (bus.WriteReg !== 1'b0) begin errors++; $display("FAIL hold_write got %b want 0", bus.WriteReg); end
        bus.mem_valid = 1'b1; bus.mem_reg = 4'd8; bus.mem_data = 16'hDEAD;
        step();
        bus.mem_valid = 1'b0;
        checks++; if (bus.count !== 3'd4 || bus.pending !== 16'h00F0) begin
            errors++; $display("FAIL hold_refuse got cnt=%0d pend=%h want 4 00f0", bus.count, bus.pending);
        end
        bus.hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'(4 + i) || bus.DstData !== 16'(16'h0040 + i)) begin
                errors++; $display("FAIL hold_drain%0d got we=%b r%0d %h want 1 r%0d %h", i, bus.WriteReg, bus.DstReg, bus.DstData, 4 + i, 16'h0040 + i);
            end
        end
        step();
        checks++; if (bus.WriteReg !== 1'b0 || bus.count !== 3'd0) begin
            errors++; $display("FAIL hold_empty got we=%b cnt=%0d want 0 0", bus.WriteReg, bus.count);
        end
    endtask

    task automatic test_back_to_back();
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.mem_valid = 1'b1;
            bus.mem_reg   = 4'(10 + k);
            bus.mem_data  = 16'(16'h0100 + k);
            step();
        end
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL stream_fill got %0d want 3", bus.count); end
        bus.hold = 1'b0;
        for (int j = 0; j < 20; j++) begin
            bus.mem_valid = 1'b1;
            bus.mem_reg   = 4'(13 + j);
            bus.mem_data  = 16'(16'h0103 + j);
            step();
            checks++; if (bus.count !== 3'd3 || bus.WriteReg !== 1'b1 || bus.DstReg !== 4'(10 + j) || bus.DstData !== 16'(16'h0100 + j)) begin
                errors++; $display("FAIL stream%0d got cnt=%0d we=%b r%0d %h want 3 1 r%0d %h", j, bus.count, bus.WriteReg, bus.DstReg, bus.DstData, (10 + j) % 16, 16'h0100 + j);
            end
        end
        bus.mem_valid = 1'b0;
        for (int j = 20; j < 23; j++) begin
            step();
            checks++; if (bus.WriteReg !== 1'b1 || bus.DstReg !== 4'(10 + j) || bus.DstData !== 16'(16'h0100 + j)) begin
                errors++; $display("FAIL stream_tail%0d got we=%b r%0d %h want 1 r%0d %h", j, bus.WriteReg, bus.DstReg, bus.DstData, (10 + j) % 16, 16'h0100 + j);
            end
        end
        step();
        checks++; if (bus.WriteReg !== 1'b0 || bus.count !== 3'd0) begin
            errors++; $display("FAIL stream_empty got we=%b cnt=%0d want 0 0", bus.WriteReg, bus.count);
        end
    endtask

    task automatic test_duplicate();
        entry_t vec [2];
        vec[0] = '{id: 4'd9, data: 16'h0001};
        vec[1] = '{id: 4'd9, data: 16'h0002};
        bus.hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_reg   = vec[i].id;
            bus.alu_data  = vec[i].data;
            step();
        end
        bus.alu_valid = 1'b0;
        checks++; if (bus.count !== 3'd2 || bus.pending !== 16'h0200) begin
            errors++; $display("FAIL dup_queued got cnt=%0d pend=%h want 2 0200", bus.count, bus.pending);
        end
        bus.hold = 1'b0;
        step();
        checks++; if (bus.DstReg !== 4'd9 || bus.DstData !== 16'h0001 || bus.pending !== 16'h0200) begin
            errors++; $display("FAIL dup_first got r%0d %h pend=%h want r9 0001 0200", bus.DstReg, bus.DstData, bus.pending);
        end
        step();
        checks++; if (bus.WriteReg !== 1'b1 || bus.DstData !== 16'h0002 || bus.pending !== 16'h0000) begin
            errors++; $display("FAIL dup_second got we=%b %h pend=%h want 1 0002 0000", bus.WriteReg, bus.DstData, bus.pending);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.mem_valid = 1'b1;
            bus.mem_reg   = 4'(1 + i);
            bus.mem_data  = 16'(16'h0A01 + i);
            step();
        end
        bus.mem_valid = 1'b0;
        checks++; if (bus.count !== 3'd3 || bus.pending !== 16'h000E) begin
            errors++; $display("FAIL rstmid_fill got cnt=%0d pend=%h want 3 000e", bus.count, bus.pending);
        end
        rst      = 1'b1;
        bus.hold = 1'b0;
        step();
        rst = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.pending !== 16'h0000 || bus.WriteReg !== 1'b0) begin
            errors++; $display("FAIL rstmid_clear got cnt=%0d pend=%h we=%b want 0 0000 0", bus.count, bus.pending, bus.WriteReg);
        end
        checks++; if (bus.DstReg !== 4'd0 || bus.DstData !== 16'h0000) begin
            errors++; $display("FAIL rstmid_dst got r%0d %h want r0 0000", bus.DstReg, bus.DstData);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.WriteReg !== 1'b0 || bus.count !== 3'd0) begin
                errors++; $display("FAIL rstmid_quiet%0d got we=%b cnt=%0d want 0 0", i, bus.WriteReg, bus.count);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_alu();
        test_priority();
        test_hold();
        test_back_to_back();
        test_duplicate();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
